// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined WIDTH-bit ALU with valid/ready handshakes.
//
// Each operand can be inverted on the way in. The four operations are AND, OR,
// XOR and ADD with carry-in. Results carry flags for carry-out and zero.
// Stage 1 registers the (optionally inverted) operands, op and carry-in.
// Stage 2 registers the result and its flags. Backpressure from out_ready
// ripples back to in_ready combinationally. in_ready has no path from in_valid.
//
// Optional feature: define ALU_PIPE_OVF_EN to add the 'overflow' output. It is
// the two's-complement signed overflow of ADD, and 0 for the logic ops.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   upstream presents an operation
//   in_ready   out  an operation can be accepted this cycle
//   a, b       in   WIDTH-bit operands
//   a_inv      in   1 = use ~a
//   b_inv      in   1 = use ~b
//   op         in   00 AND, 01 OR, 10 XOR, 11 ADD
//   carry_in   in   carry into ADD (ignored for logic ops)
//   out_valid  out  result/flags valid
//   out_ready  in   downstream accepts the result
//   result     out  WIDTH-bit result
//   carry_out  out  ADD carry out of the MSB, 0 for logic ops
//   zero       out  result == 0
//   overflow   out  signed overflow of ADD (only with ALU_PIPE_OVF_EN)
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_inv,
    input  logic             b_inv,
    input  logic [1:0]       op,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
`ifdef ALU_PIPE_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    // Stage 1 registers
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       op_r;
    logic             cin_r;
    logic             s1_valid_r;

    // Stage 2 registers
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             zero_r;
    logic             s2_valid_r;

    // Handshake / advance control
    logic             adv1_s;
    logic             adv2_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    // Stage 2 combinational results
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;

    // Stage 2 can load when it is empty or its content leaves this cycle.
    // Stage 1 can load when it is empty or its content moves to stage 2.
    assign adv2_s     = s1_valid_r && (!s2_valid_r || out_ready);
    assign adv1_s     = !s1_valid_r || adv2_s;
    assign in_xfer_s  = in_valid && adv1_s;
    assign out_xfer_s = s2_valid_r && out_ready;

    assign in_ready   = adv1_s;
    assign out_valid  = s2_valid_r;
    assign result     = result_r;
    assign carry_out  = carry_r;
    assign zero       = zero_r;

    // ADD is evaluated in WIDTH+1 bits so the top bit is the carry out of the MSB.
    assign sum_s = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};

    // Operation select for the stage-2 result and carry flag.
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        case (op_r)
            OP_AND:  res_s = a_r & b_r;
            OP_OR:   res_s = a_r | b_r;
            OP_XOR:  res_s = a_r ^ b_r;
            OP_ADD: begin
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
            end
            default: begin
                res_s   = {WIDTH{1'b0}};
                carry_s = 1'b0;
            end
        endcase
    end

    // Stage 1: capture the conditioned operands on input transfer, and empty out when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            op_r       <= 2'b00;
            cin_r      <= 1'b0;
            s1_valid_r <= 1'b0;
        end else if (in_xfer_s) begin
            a_r        <= a_inv ? ~a : a;
            b_r        <= b_inv ? ~b : b;
            op_r       <= op;
            cin_r      <= carry_in;
            s1_valid_r <= 1'b1;
        end else if (adv2_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: register the result and flags. They hold until replaced, so they stay stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r   <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            zero_r     <= 1'b0;
            s2_valid_r <= 1'b0;
        end else if (adv2_s) begin
            result_r   <= res_s;
            carry_r    <= carry_s;
            zero_r     <= (res_s == {WIDTH{1'b0}});
            s2_valid_r <= 1'b1;
        end else if (out_xfer_s) begin
            s2_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

`ifdef ALU_PIPE_OVF_EN
    logic ovf_s;
    logic overflow_r;

    // Signed overflow: both operands have the same sign, and the sum has the other sign.
    always_comb begin
        ovf_s = 1'b0;
        if (op_r == OP_ADD) begin
            ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Overflow flag is registered alongside the stage-2 result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (adv2_s) begin
            overflow_r <= ovf_s;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow = overflow_r;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe (WIDTH = 8). Inputs are driven 1 ns after the
// rising edge. Outputs are sampled 1 ns after the edge, or mid-cycle.
module tb_alu_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
    logic       carry_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;
`ifdef ALU_PIPE_OVF_EN
    logic       overflow;
`endif

    int n_vec;
    int n_err;

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_inv     (a_inv),
        .b_inv     (b_inv),
        .op        (op),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
`ifdef ALU_PIPE_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time bound
    initial begin
        #100000;
        $display("FAIL timeout: observed simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s miscompare", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic ai,
                         input logic bi, input logic [1:0] vop, input logic cin);
        a        = va;
        b        = vb;
        a_inv    = ai;
        b_inv    = bi;
        op       = vop;
        carry_in = cin;
        in_valid = 1'b1;
    endtask

    // Present one op with out_ready=1. Check 2-cycle latency, then result and flags.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic ai, input logic bi, input logic [1:0] vop, input logic cin,
                          input logic [7:0] er, input logic ec, input logic ez);
        check({tag, "_rdy"}, in_ready, 1'b1);
        drive(va, vb, ai, bi, vop, cin);
        tick();                       // accepted here
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 1'b0);
        tick();
        check({tag, "_vld"}, out_valid, 1'b1);
        check({tag, "_res"}, result, er);
        check({tag, "_cy"}, carry_out, ec);
        check({tag, "_z"}, zero, ez);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(8'hAA, 8'h55, 1'b0, 1'b0, 2'b11, 1'b1);

        // Reset with in_valid held high
        tick();
        tick();
        check("rst_ovld", out_valid, 1'b0);
        check("rst_res", result, 8'h00);
        check("rst_cy", carry_out, 1'b0);
        check("rst_z", zero, 1'b0);
`ifdef ALU_PIPE_OVF_EN
        check("rst_ovf", overflow, 1'b0);
`endif
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        check("rst_rdy", in_ready, 1'b1);
        check("rst_ovld2", out_valid, 1'b0);

        // ADD 0x7F + 0x01
        run_op("add", 8'h7F, 8'h01, 1'b0, 1'b0, 2'b11, 1'b0, 8'h80, 1'b0, 1'b0);
`ifdef ALU_PIPE_OVF_EN
        check("add_ovf", overflow, 1'b1);
`endif
        // SUB 5 - 5, then 3 - 5
        run_op("sub0", 8'h05, 8'h05, 1'b0, 1'b1, 2'b11, 1'b1, 8'h00, 1'b1, 1'b1);
`ifdef ALU_PIPE_OVF_EN
        check("sub0_ovf", overflow, 1'b0);
`endif
        run_op("subn", 8'h03, 8'h05, 1'b0, 1'b1, 2'b11, 1'b1, 8'hFE, 1'b0, 1'b0);

        // Logic ops with a_inv: A' = 0x0F, B = 0x3C. carry_in=1 must be ignored.
        run_op("and", 8'hF0, 8'h3C, 1'b1, 1'b0, 2'b00, 1'b1, 8'h0C, 1'b0, 1'b0);
        run_op("or",  8'hF0, 8'h3C, 1'b1, 1'b0, 2'b01, 1'b1, 8'h3F, 1'b0, 1'b0);
        run_op("xor", 8'hF0, 8'h3C, 1'b1, 1'b0, 2'b10, 1'b1, 8'h33, 1'b0, 1'b0);
`ifdef ALU_PIPE_OVF_EN
        check("xor_ovf", overflow, 1'b0);
`endif
        tick();
        check("drain", out_valid, 1'b0);

        // Backpressure: three back-to-back ADDs with out_ready low
        out_ready = 1'b0;
        drive(8'h01, 8'h01, 1'b0, 1'b0, 2'b11, 1'b0);
        check("bp_rdy0", in_ready, 1'b1);
        tick();
        drive(8'h02, 8'h02, 1'b0, 1'b0, 2'b11, 1'b0);
        check("bp_rdy1", in_ready, 1'b1);
        tick();
        drive(8'h03, 8'h03, 1'b0, 1'b0, 2'b11, 1'b0);
        check("bp_full", in_ready, 1'b0);
        check("bp_vld", out_valid, 1'b1);
        check("bp_hold0", result, 8'h02);
        tick();
        check("bp_full2", in_ready, 1'b0);
        check("bp_hold1", result, 8'h02);
        check("bp_vld2", out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        check("bp_simul_rdy", in_ready, 1'b1);
        check("bp_out1", result, 8'h02);
        tick();                       // 0x02 leaves, 3+3 accepted
        in_valid = 1'b0;
        check("bp_out2", result, 8'h04);
        check("bp_vld3", out_valid, 1'b1);
        tick();
        check("bp_out3", result, 8'h06);
        check("bp_vld4", out_valid, 1'b1);
        tick();
        check("bp_empty", out_valid, 1'b0);

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        drive(8'h11, 8'h22, 1'b0, 1'b0, 2'b11, 1'b0);
        tick();
        drive(8'h44, 8'h11, 1'b0, 1'b0, 2'b01, 1'b0);
        tick();
        in_valid = 1'b0;
        check("mid_full", in_ready, 1'b0);
        check("mid_res", result, 8'h33);
        #2;
        rst = 1'b1;
        #1;
        check("mid_ovld", out_valid, 1'b0);
        check("mid_rres", result, 8'h00);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rdy", in_ready, 1'b1);
        run_op("post", 8'h10, 8'h10, 1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("post_drain", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
